gate_sweep_tester: RTL

- Sequential stimulus/checker stage wrapped around a 2-input combinational gate (default: NAND).
- Upstream side: drives x1/x2 through all four input vectors.
- Downstream side: samples the gate output y after a settle window and compares it against a parameterised truth table.
- Reports error count, per-vector fail bitmap and pass/done status for lab self-test of gate cells.

---
 rtl/gate_sweep_if.sv | 38 +++
 rtl/gate_sweep_tester.sv | 119 +++++++++++
 2 files changed

// File: rtl/gate_sweep_if.sv
// Stimulus/status bundle between the gate sweep tester (master) and the lab harness (slave).
// The cont line exists only when GATE_TESTER_CONT_EN is defined.
interface gate_sweep_if #(
  parameter int unsigned ERR_W = 8
);
  logic             start;
  logic             x1;
  logic             x2;
  logic             y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [3:0]       fail_vec;
`ifdef GATE_TESTER_CONT_EN
  logic             cont;

  modport master (
    input  start, y, cont,
    output x1, x2, busy, done, pass, err_cnt, fail_vec
  );

  modport slave (
    output start, y, cont,
    input  x1, x2, busy, done, pass, err_cnt, fail_vec
  );
`else
  modport master (
    input  start, y,
    output x1, x2, busy, done, pass, err_cnt, fail_vec
  );

  modport slave (
    output start, y,
    input  x1, x2, busy, done, pass, err_cnt, fail_vec
  );
`endif
endinterface

// File: rtl/gate_sweep_tester.sv
// Walks a 2-input gate through all four input vectors and checks y against TRUTH.
// Optional GATE_TESTER_CONT_EN adds back-to-back sweeps with accumulating results.
module gate_sweep_tester #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  TRUTH         = 4'b0111,
  parameter int unsigned ERR_W         = 8
) (
  input logic          clk,
  input logic          rst_n,
  gate_sweep_if.master bus
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    FINISH
  } state_t;

  state_t           r_state;
  logic [1:0]       r_vec;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_x;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [3:0]       r_fail;

  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_nxt;
  logic             w_cont;

  assign w_mismatch = (bus.y != TRUTH[r_vec]);
  // Saturating error count including the current sample.
  assign w_err_nxt  = !w_mismatch              ? r_err :
                      (r_err == {ERR_W{1'b1}}) ? r_err : r_err + 1'b1;

`ifdef GATE_TESTER_CONT_EN
  assign w_cont = bus.cont;
`else
  assign w_cont = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_vec   <= 2'd0;
      r_cnt   <= '0;
      r_x     <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_fail  <= 4'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= DRIVE;
            r_vec   <= 2'd0;
            r_x     <= 2'd0;
            r_busy  <= 1'b1;
            r_err   <= '0;
            r_fail  <= 4'd0;
          end
        end
        DRIVE: begin
          r_cnt   <= CNT_W'(SETTLE_CYCLES);
          r_state <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
        end
        SETTLE: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) r_state <= SAMPLE;
        end
        SAMPLE: begin
          r_err <= w_err_nxt;
          if (w_mismatch) r_fail[r_vec] <= 1'b1;
          // Last vector: status becomes visible in the FINISH cycle.
          if (r_vec == 2'd3) begin
            r_state <= FINISH;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_x     <= 2'd0;
            r_pass  <= (w_err_nxt == '0);
          end else begin
            r_state <= DRIVE;
            r_vec   <= r_vec + 2'd1;
            r_x     <= r_vec + 2'd1;
          end
        end
        FINISH: begin
          if (w_cont) begin
            r_state <= DRIVE;
            r_vec   <= 2'd0;
            r_x     <= 2'd0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.x1       = r_x[1];
  assign bus.x2       = r_x[0];
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.pass     = r_pass;
  assign bus.err_cnt  = r_err;
  assign bus.fail_vec = r_fail;

endmodule
